// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage interlock for the 5-stage pipeline: decodes the ID opcode into
// registered EX controls, tracks in-flight producers and raises stall on RAW hazards.
module pipe_hazard_ctrl #(
  parameter int FORWARD = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [5:0]       id_opcode,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic             flush,
  output logic             stall,
  output logic             issue,
  output logic             ex_regwrite,
  output logic             ex_memwrite,
  output logic             ex_memread,
  output logic [1:0]       ex_aluop,
  output logic [4:0]       ex_dest,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  logic       dec_regwrite;
  logic       dec_memwrite;
  logic       dec_memread;
  logic [1:0] dec_aluop;
  logic [4:0] dec_dest;
  logic       use_rs;
  logic       use_rt;

  logic       ex_valid;
  logic       mem_valid;
  logic       mem_regwrite;
  logic [4:0] mem_dest;

  logic       ex_hit;
  logic       mem_hit;
  logic       raw;

  always_comb begin
    dec_regwrite = 1'b0;
    dec_memwrite = 1'b0;
    dec_memread  = 1'b0;
    dec_aluop    = 2'b11;
    dec_dest     = 5'd0;
    use_rs       = 1'b0;
    use_rt       = 1'b0;
    case (id_opcode)
      OP_RTYPE: begin
        dec_regwrite = 1'b1;
        dec_aluop    = 2'b10;
        dec_dest     = id_rd;
        use_rs       = 1'b1;
        use_rt       = 1'b1;
      end
      OP_LW: begin
        dec_regwrite = 1'b1;
        dec_memread  = 1'b1;
        dec_aluop    = 2'b00;
        dec_dest     = id_rt;
        use_rs       = 1'b1;
      end
      OP_SW: begin
        dec_memwrite = 1'b1;
        dec_aluop    = 2'b00;
        use_rs       = 1'b1;
        use_rt       = 1'b1;
      end
      default: ;
    endcase
  end

  // A producer with dest 0 never matches, which also keeps $0 sources hazard-free.
  always_comb begin
    ex_hit  = ex_valid && ex_regwrite && (ex_dest != 5'd0) &&
              ((use_rs && (id_rs == ex_dest)) || (use_rt && (id_rt == ex_dest)));
    mem_hit = mem_valid && mem_regwrite && (mem_dest != 5'd0) &&
              ((use_rs && (id_rs == mem_dest)) || (use_rt && (id_rt == mem_dest)));
    if (FORWARD != 0) raw = ex_hit && ex_memread;
    else              raw = ex_hit || mem_hit;
    stall = id_valid && !flush && raw;
    issue = id_valid && !flush && !raw;
  end

  // The WB entry can never cause a stall (register file writes first), so only
  // EX and MEM are kept; the pipeline shifts every cycle with no back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_regwrite  <= 1'b0;
      ex_memwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      ex_aluop     <= 2'b11;
      ex_dest      <= 5'd0;
      mem_valid    <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_dest     <= 5'd0;
    end else begin
      mem_valid    <= ex_valid;
      mem_regwrite <= ex_regwrite;
      mem_dest     <= ex_dest;
      if (issue) begin
        ex_valid    <= 1'b1;
        ex_regwrite <= dec_regwrite;
        ex_memwrite <= dec_memwrite;
        ex_memread  <= dec_memread;
        ex_aluop    <= dec_aluop;
        ex_dest     <= dec_dest;
      end else begin
        ex_valid    <= 1'b0;
        ex_regwrite <= 1'b0;
        ex_memwrite <= 1'b0;
        ex_memread  <= 1'b0;
        ex_aluop    <= 2'b11;
        ex_dest     <= 5'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three instances (forwarding, no forwarding, 4-bit counter)
// share one stimulus stream and are checked against an in-flight instruction model.
module tb_pipe_hazard_ctrl;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_NOP = 6'b001000;

  typedef struct packed {
    logic       v;
    logic       rw;
    logic       mr;
    logic       mw;
    logic [1:0] op;
    logic [4:0] dest;
  } rec_t;

  localparam rec_t BUBBLE = '{v: 1'b0, rw: 1'b0, mr: 1'b0, mw: 1'b0, op: 2'b11, dest: 5'd0};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [5:0] id_opcode;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       flush;

  logic        st0, is0, rw0, mw0, mr0;
  logic [1:0]  op0;
  logic [4:0]  d0;
  logic [15:0] c0;
  logic        st1, is1, rw1, mw1, mr1;
  logic [1:0]  op1;
  logic [4:0]  d1;
  logic [15:0] c1;
  logic        st2, is2, rw2, mw2, mr2;
  logic [1:0]  op2;
  logic [4:0]  d2;
  logic [3:0]  c2;

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  rec_t mex [3];
  rec_t mmem[3];
  int   mcnt[3];
  int   fw  [3] = '{1, 0, 1};
  int   cmax[3] = '{65535, 65535, 15};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FORWARD(1), .CNT_W(16)) dut_f1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
    .stall(st0), .issue(is0), .ex_regwrite(rw0), .ex_memwrite(mw0),
    .ex_memread(mr0), .ex_aluop(op0), .ex_dest(d0), .stall_count(c0));

  pipe_hazard_ctrl #(.FORWARD(0), .CNT_W(16)) dut_f0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
    .stall(st1), .issue(is1), .ex_regwrite(rw1), .ex_memwrite(mw1),
    .ex_memread(mr1), .ex_aluop(op1), .ex_dest(d1), .stall_count(c1));

  pipe_hazard_ctrl #(.FORWARD(1), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
    .stall(st2), .issue(is2), .ex_regwrite(rw2), .ex_memwrite(mw2),
    .ex_memread(mr2), .ex_aluop(op2), .ex_dest(d2), .stall_count(c2));

  function automatic rec_t decode(logic [5:0] op, logic [4:0] rt, logic [4:0] rd);
    rec_t r = BUBBLE;
    r.v = 1'b1;
    if (op == OP_R) begin
      r.rw = 1'b1; r.op = 2'b10; r.dest = rd;
    end else if (op == OP_LW) begin
      r.rw = 1'b1; r.mr = 1'b1; r.op = 2'b00; r.dest = rt;
    end else if (op == OP_SW) begin
      r.mw = 1'b1; r.op = 2'b00;
    end
    return r;
  endfunction

  function automatic logic reads(rec_t p, logic [5:0] op, logic [4:0] rs, logic [4:0] rt);
    if (!(p.v && p.rw && p.dest != 5'd0)) return 1'b0;
    if (op == OP_R || op == OP_SW) return (rs == p.dest) || (rt == p.dest);
    if (op == OP_LW) return rs == p.dest;
    return 1'b0;
  endfunction

  function automatic logic model_stall(int i);
    logic ex_dep, mem_dep;
    ex_dep  = reads(mex[i], id_opcode, id_rs, id_rt);
    mem_dep = reads(mmem[i], id_opcode, id_rs, id_rt);
    if (!id_valid || flush) return 1'b0;
    if (fw[i] != 0) return ex_dep && mex[i].mr;
    return ex_dep || mem_dep;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        mex[i]  <= BUBBLE;
        mmem[i] <= BUBBLE;
        mcnt[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (model_stall(i) && mcnt[i] < cmax[i]) mcnt[i] <= mcnt[i] + 1;
        mmem[i] <= mex[i];
        if (id_valid && !flush && !model_stall(i)) mex[i] <= decode(id_opcode, id_rt, id_rd);
        else mex[i] <= BUBBLE;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic checkOutput(input int i, input logic st, input logic is, input logic rw,
                             input logic mw, input logic mr, input logic [1:0] op,
                             input logic [4:0] d, input int cnt);
    logic es;
    es = model_stall(i);
    chk($sformatf("dut%0d_stall", i), int'(st), int'(es));
    chk($sformatf("dut%0d_issue", i), int'(is), int'(id_valid && !flush && !es));
    chk($sformatf("dut%0d_regwrite", i), int'(rw), int'(mex[i].rw));
    chk($sformatf("dut%0d_memwrite", i), int'(mw), int'(mex[i].mw));
    chk($sformatf("dut%0d_memread", i), int'(mr), int'(mex[i].mr));
    chk($sformatf("dut%0d_aluop", i), int'(op), int'(mex[i].op));
    chk($sformatf("dut%0d_dest", i), int'(d), int'(mex[i].dest));
    chk($sformatf("dut%0d_count", i), cnt, mcnt[i]);
  endtask

  always @(negedge clk) begin
    if (checking) begin
      checkOutput(0, st0, is0, rw0, mw0, mr0, op0, d0, int'(c0));
      checkOutput(1, st1, is1, rw1, mw1, mr1, op1, d1, int'(c1));
      checkOutput(2, st2, is2, rw2, mw2, mr2, op2, d2, int'(c2));
    end
  end

  task automatic applyStimulus(input logic v, input logic [5:0] op, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd, input logic fl);
    @(posedge clk);
    #1;
    id_valid  = v;
    id_opcode = op;
    id_rs     = rs;
    id_rt     = rt;
    id_rd     = rd;
    flush     = fl;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    id_valid = 1'b0; id_opcode = OP_NOP; id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0; flush = 1'b0;
    checking = 1'b1;
    @(negedge clk);
    chk("reset_aluop", int'(op0), 3);
    chk("reset_regwrite", int'(rw1), 0);
    chk("reset_count", int'(c0), 0);
    chk("reset_stall", int'(st1), 0);
    rst_n = 1'b1;

    // Load-use: lw $2 then R-type reading $2
    applyStimulus(1'b1, OP_LW, 5'd0, 5'd2, 5'd0, 1'b0);
    applyStimulus(1'b1, OP_R, 5'd2, 5'd3, 5'd7, 1'b0);
    chk("lu_f1_stall_t1", int'(st0), 1);
    chk("lu_f0_stall_t1", int'(st1), 1);
    applyStimulus(1'b1, OP_R, 5'd2, 5'd3, 5'd7, 1'b0);
    chk("lu_f1_stall_t2", int'(st0), 0);
    chk("lu_f1_issue_t2", int'(is0), 1);
    chk("lu_f0_stall_t2", int'(st1), 1);
    applyStimulus(1'b1, OP_R, 5'd2, 5'd3, 5'd7, 1'b0);
    chk("lu_f0_issue_t3", int'(is1), 1);
    chk("lu_f1_ex_aluop", int'(op0), 2);
    chk("lu_f1_ex_dest", int'(d0), 7);
    chk("lu_f1_count", int'(c0), 1);
    chk("lu_f0_count", int'(c1), 2);
    idle(3);

    // R-type writing $5 then sw reading $5 as rt
    applyStimulus(1'b1, OP_R, 5'd1, 5'd1, 5'd5, 1'b0);
    applyStimulus(1'b1, OP_SW, 5'd0, 5'd5, 5'd0, 1'b0);
    chk("rr_f0_stall_t1", int'(st1), 1);
    chk("rr_f1_stall_t1", int'(st0), 0);
    applyStimulus(1'b1, OP_SW, 5'd0, 5'd5, 5'd0, 1'b0);
    chk("rr_f0_stall_t2", int'(st1), 1);
    applyStimulus(1'b1, OP_SW, 5'd0, 5'd5, 5'd0, 1'b0);
    chk("rr_f0_issue_t3", int'(is1), 1);
    chk("rr_f0_count", int'(c1), 4);
    idle(3);

    // Register 0 never creates a dependency
    applyStimulus(1'b1, OP_LW, 5'd0, 5'd0, 5'd0, 1'b0);
    applyStimulus(1'b1, OP_R, 5'd0, 5'd0, 5'd1, 1'b0);
    chk("r0_f1_stall", int'(st0), 0);
    chk("r0_f0_stall", int'(st1), 0);
    idle(3);

    // Flush coinciding with a load-use hazard
    applyStimulus(1'b1, OP_LW, 5'd0, 5'd4, 5'd0, 1'b0);
    applyStimulus(1'b1, OP_R, 5'd4, 5'd0, 5'd2, 1'b1);
    chk("fl_f1_stall", int'(st0), 0);
    chk("fl_f1_issue", int'(is0), 0);
    chk("fl_f0_stall", int'(st1), 0);
    idle(1);
    chk("fl_f1_aluop", int'(op0), 3);
    chk("fl_f0_aluop", int'(op1), 3);
    chk("fl_f1_count", int'(c0), 1);
    chk("fl_f0_count", int'(c1), 4);

    // Reset mid-stream with an lw in EX
    applyStimulus(1'b1, OP_LW, 5'd0, 5'd6, 5'd0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    id_opcode = OP_R; id_rs = 5'd6; id_rt = 5'd0; id_rd = 5'd3;
    #1;
    chk("mr_regwrite", int'(rw0), 0);
    chk("mr_aluop", int'(op0), 3);
    chk("mr_count", int'(c1), 0);
    chk("mr_stall", int'(st0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, OP_R, 5'd6, 5'd0, 5'd3, 1'b0);
    chk("mr_post_f1_stall", int'(st0), 0);
    chk("mr_post_f0_stall", int'(st1), 0);
    idle(3);

    // Repeated lw/use pairs to drive the 4-bit counter into saturation
    for (int k = 0; k < 25; k++) begin
      applyStimulus(1'b1, OP_LW, 5'd0, 5'd3, 5'd0, 1'b0);
      applyStimulus(1'b1, OP_R, 5'd3, 5'd0, 5'd1, 1'b0);
      applyStimulus(1'b1, OP_R, 5'd3, 5'd0, 5'd1, 1'b0);
    end
    idle(1);
    chk("sat_count4", int'(c2), 15);
    chk("sat_f1_count", int'(c0), 25);
    chk("sat_f0_count", int'(c1), 50);

    // Randomized traffic over a small register set so hazards are frequent
    for (int k = 0; k < 800; k++) begin
      @(posedge clk);
      #1;
      rst_n     = ($urandom_range(0, 99) != 0);
      id_valid  = ($urandom_range(0, 9) < 8);
      flush     = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0: id_opcode = OP_R;
        1: id_opcode = OP_LW;
        2: id_opcode = OP_SW;
        default: id_opcode = OP_NOP;
      endcase
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      id_rd = 5'($urandom_range(0, 3));
      @(negedge clk);
    end
    rst_n = 1'b1;
    idle(2);

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Decode-stage interlock and issue scheduler for the 5-stage pipeline. It decodes the ID-stage opcode into EX control signals and keeps a 3-entry shadow of in-flight instructions (EX, MEM, WB). From that shadow it raises `stall` on read-after-write hazards, inserts bubbles, honours branch flushes, and counts stall cycles. It sits between the IF/ID register and the ID/EX register, and its registered control outputs form the control half of the ID/EX register.

## Interface
- `FORWARD`, default 1: 1 means a forwarding unit exists and only load-use stalls; 0 means no forwarding and every EX/MEM RAW dependency stalls.
- `CNT_W`, default 16: width of the stall counter.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `id_valid` input 1: the IF/ID register holds a real instruction.
- `id_opcode` input 6: opcode of the ID instruction.
- `id_rs`, `id_rt`, `id_rd` input 5 each: register fields of the ID instruction.
- `flush` input 1: branch taken/mispredicted; kill the ID instruction this cycle.
- `stall` output 1: hold PC and IF/ID (combinational).
- `issue` output 1: the ID instruction is accepted into EX this cycle (combinational).
- `ex_regwrite`, `ex_memwrite`, `ex_memread` output 1 each: registered EX-stage controls.
- `ex_aluop` output 2: registered EX-stage ALU op.
- `ex_dest` output 5: registered destination register of the EX instruction.
- `stall_count` output CNT_W: saturating count of stall cycles.

## Operation
- **Decode** (ID instruction):
  - 000000 (R-type): regwrite=1, dest=rd, aluop=10, sources rs and rt.
  - 100011 (lw): regwrite=1, memread=1, dest=rt, aluop=00, source rs.
  - 101011 (sw): memwrite=1, aluop=00, sources rs and rt, no dest.
  - Any other opcode: no-op controls (all 0, aluop=11), no sources.
- **Shadow entries** hold {valid, regwrite, memread, dest}. An entry is a hazard producer only if valid=1, regwrite=1 and dest≠0.
- **Hazard check** (evaluated only when `id_valid`=1):
  - FORWARD=1: `stall` when the EX entry has memread=1 and its dest equals a used source of the ID instruction.
  - FORWARD=0: `stall` when the EX or MEM entry's dest equals a used source.
  - The WB entry never causes a stall; the register file writes first.
- **Flush**:
  - flush=1 forces stall=0 and issue=0; a bubble enters EX.
  - The EX, MEM and WB entries are not affected.
- **Issue**: issue = id_valid & ~stall & ~flush.
- **Shift**: every cycle, unconditionally, WB←MEM, MEM←EX, and EX←(issue ? decoded ID instruction : bubble). There is no downstream back-pressure.
- **Bubble**: valid=0, regwrite=0, memwrite=0, memread=0, aluop=11, dest=0.
- **Stall counter**: increments on each cycle with stall=1 and saturates at all-ones.

## Timing
- **Reset** (rst_n low, asynchronous): all shadow entries become bubbles, so ex_regwrite=0, ex_memwrite=0, ex_memread=0, ex_aluop=11, ex_dest=0. stall_count=0. `stall` and `issue` are then 0 unless id_valid=1.
- **Reset mid-operation**: in-flight entries are discarded immediately. The first rising edge after release loads EX from the current ID inputs.
- **Output latency**: `stall` and `issue` are combinational, valid in the same cycle as the ID inputs. ex_* outputs appear 1 clock after `issue`.
- **Load-use, FORWARD=1**: lw issued at cycle t; a dependent instruction in ID at t+1 sees stall=1; it issues at t+2.
- **Load-use, FORWARD=0**: stall=1 at t+1 and t+2; the dependent instruction issues at t+3.
- **R-type dependency**: FORWARD=1 gives 0 stalls; FORWARD=0 gives 2 stalls.
- **Register 0**: a source or dest of 0 never matches.
- **Simultaneous flush and hazard**: flush wins, so stall=0 and the counter does not increment.
- **id_valid=0**: stall=0 and a bubble is inserted.

## Test plan
- **Reset**: assert rst_n=0 mid-stream with an lw in EX. Required: ex_regwrite=0, ex_aluop=11, stall_count=0 immediately; after release, no stall from the pre-reset lw.
- **Load-use, FORWARD=1**: lw $2 ← (opcode 100011, rt=2), then R-type with rs=2. Required: stall=1 for exactly 1 cycle, stall_count=1, the R-type issues 2 cycles after the lw and appears with ex_aluop=10, ex_dest=rd.
- **Dependencies, FORWARD=0**: R-type writing $5 followed by sw reading rt=5. Required: stall=1 for 2 cycles, then issue; stall_count=2.
- **Register 0**: lw to $0 followed by a user of $0. Required: stall=0 in both FORWARD modes.
- **Flush vs. stall**: a load-use hazard present with flush=1 in the same cycle. Required: stall=0, issue=0, a bubble in EX next cycle (ex_aluop=11), stall_count unchanged.
- **Saturation**: with CNT_W=4, hold a hazard so 20 stall cycles occur (repeated lw/use). Required: stall_count stops at 15 and does not wrap.
